// File: rtl/adder3_sequencer.sv
// adder3_sequencer: sequencing controller for a shared 3-bit ripple-carry adder.
// It collects operand A (with its mode bit) and then operand B over io_in.
// It drives the adder once for an add, or three times for a shift-add multiply.
// It registers a 6-bit result on io_out[5:0], with busy and done on io_out[7:6].
// Optional feature: define ADDER3_SEQ_ACCUM_EN to accumulate results mod 64
// instead of overwriting them.
module adder3_sequencer (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam int DATA_W = 3;
  localparam int RES_W  = 6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_B = 3'd1,
    ADD    = 3'd2,
    MUL0   = 3'd3,
    MUL1   = 3'd4,
    MUL2   = 3'd5,
    DONE   = 3'd6
  } state_t;

  logic              clk;
  logic              rst_n;
  logic              valid;
  logic              mode;
  logic [DATA_W-1:0] data;
  logic              clear;

  assign clk   = io_in[0];
  assign rst_n = io_in[1];
  assign valid = io_in[2];
  assign mode  = io_in[3];
  assign data  = io_in[6:4];
  assign clear = io_in[7];

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              mode_r;
  logic [RES_W-1:0]  prod;
  logic [RES_W-1:0]  result;
  logic [DATA_W-1:0] add_x;
  logic [DATA_W-1:0] add_y;
  logic [DATA_W:0]   add_sum;
  logic [RES_W-1:0]  prod_next;
  logic [RES_W-1:0]  final_x;
  logic [RES_W-1:0]  result_next;
  logic              final_wr;
  logic              busy;
  logic              done;

  // The single shared 3-bit adder; the carry-out becomes bit 3 of the sum.
  function automatic logic [DATA_W:0] add3(input logic [DATA_W-1:0] x,
                                           input logic [DATA_W-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  // State register, reset straight to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; clear overrides every other transition.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (valid) state_next = WAIT_B;
        WAIT_B:  if (valid) state_next = mode_r ? MUL0 : ADD;
        ADD:     state_next = DONE;
        MUL0:    state_next = MUL1;
        MUL1:    state_next = MUL2;
        MUL2:    state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Status outputs decoded purely from the state register.
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Steer the shared adder: A+B for add, or partial product plus gated A per multiply step.
  always_comb begin
    add_x = op_a;
    add_y = op_b;
    case (state)
      MUL0: begin
        add_x = prod[2:0];
        add_y = op_b[0] ? op_a : '0;
      end
      MUL1: begin
        add_x = prod[3:1];
        add_y = op_b[1] ? op_a : '0;
      end
      MUL2: begin
        add_x = prod[4:2];
        add_y = op_b[2] ? op_a : '0;
      end
      default: ;
    endcase
  end

  assign add_sum = add3(add_x, add_y);

  // Splice the adder output into the partial product and pick the value to write back.
  always_comb begin
    prod_next = prod;
    final_x   = {2'b00, add_sum};
    final_wr  = 1'b0;
    case (state)
      ADD:  final_wr = 1'b1;
      MUL0: prod_next[3:0] = add_sum;
      MUL1: prod_next[4:1] = add_sum;
      MUL2: begin
        prod_next[5:2] = add_sum;
        final_x        = prod_next;
        final_wr       = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ADDER3_SEQ_ACCUM_EN
  // Accumulate mode: the 6-bit sum wraps naturally mod 64.
  assign result_next = result + final_x;
`else
  assign result_next = final_x;
`endif

  // Operand capture, partial-product update and result write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      mode_r <= 1'b0;
      prod   <= '0;
      result <= '0;
    end else if (clear) begin
      result <= '0;
    end else begin
      case (state)
        IDLE: if (valid) begin
          op_a   <= data;
          mode_r <= mode;
        end
        WAIT_B: if (valid) begin
          op_b <= data;
          prod <= '0;
        end
        MUL0, MUL1, MUL2: prod <= prod_next;
        default: ;
      endcase
      if (final_wr) result <= result_next;
    end
  end

  assign io_out = {done, busy, result};

endmodule

// File: tb/tb_adder3_sequencer.sv
// Bench for adder3_sequencer: a transaction-level model predicts io_out every
// cycle, and literal expectations pin the model's results.
// Build with ADDER3_SEQ_ACCUM_EN defined to run the accumulate sequence.
module tb_adder3_sequencer;

  logic       clk    = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst_n  = 1'b1;
  logic       valid  = 1'b0;
  logic       mode   = 1'b0;
  logic [2:0] data   = 3'd0;
  logic       clear  = 1'b0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign io_in = {clear, data, mode, valid, rst_n, clk};

  adder3_sequencer dut (
    .io_in (io_in),
    .io_out(io_out)
  );

  always #5 if (clk_en) clk = ~clk;

  int tests    = 0;
  int fails    = 0;
  int done_cnt = 0;

  // Model: operation-level view (have A? cycles left to compute? done showing?).
  bit         m_have_a;
  bit         m_done;
  bit         m_mode;
  int         m_cnt;
  int         m_a;
  int         m_op;
  logic [5:0] m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_have_a = 0; m_done = 0; m_mode = 0; m_cnt = 0; m_a = 0; m_op = 0;
      m_res = 6'd0;
    end else if (clear) begin
      m_have_a = 0; m_done = 0; m_cnt = 0; m_res = 6'd0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
`ifdef ADDER3_SEQ_ACCUM_EN
        m_res = 6'((int'(m_res) + m_op) % 64);
`else
        m_res = 6'(m_op % 64);
`endif
        m_done = 1;
      end
    end else if (m_have_a) begin
      if (valid) begin
        m_op     = m_mode ? m_a * int'(data) : m_a + int'(data);
        m_cnt    = m_mode ? 3 : 1;
        m_have_a = 0;
      end
    end else if (valid) begin
      m_a      = int'(data);
      m_mode   = mode;
      m_have_a = 1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      tests++;
      if (io_out !== {m_done, (m_have_a || m_cnt > 0 || m_done), m_res}) begin
        fails++;
        $display("FAIL cycle_io_out t=%0t actual=%h required=%h", $time, io_out,
                 {m_done, (m_have_a || m_cnt > 0 || m_done), m_res});
      end
    end
    if (io_out[7] === 1'b1) done_cnt++;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input bit m, input logic [2:0] d, input bit c);
    @(negedge clk);
    valid = v; mode = m; data = d; clear = c;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 3'd0, 0);
  endtask

  task automatic op(input logic [2:0] a, input logic [2:0] b, input bit mul);
    drive(1, mul, a, 0);
    drive(1, 0, b, 0);
    idle(6);
  endtask

  initial begin
    // Asynchronous reset with the clock stopped.
    #3 rst_n = 1'b0;
    #2 check("reset_async", io_out, 8'h00);
    clk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    check("reset_idle", io_out, 8'h00);

`ifdef ADDER3_SEQ_ACCUM_EN
    op(3'd3, 3'd4, 0);
    check("acc_add_1", io_out, 8'h07);
    op(3'd3, 3'd4, 0);
    check("acc_add_2", io_out, 8'h0E);
    drive(0, 0, 3'd0, 1);
    idle(1);
    check("acc_clear_1", io_out, 8'h00);
    op(3'd7, 3'd7, 1);
    check("acc_mul_1", io_out, 8'h31);
    op(3'd7, 3'd7, 1);
    check("acc_mul_2", io_out, 8'h22);
    drive(0, 0, 3'd0, 1);
    idle(1);
    check("acc_clear_2", io_out, 8'h00);
    check_int("acc_done_count", done_cnt, 4);
`else
    op(3'd5, 3'd6, 0);
    check("add_5_6", io_out, 8'h0B);
    op(3'd7, 3'd7, 0);
    check("add_7_7", io_out, 8'h0E);
    op(3'd0, 3'd6, 1);
    check("mul_0_6", io_out, 8'h00);
    op(3'd7, 3'd7, 1);
    check("mul_7_7", io_out, 8'h31);
    op(3'd5, 3'd3, 1);
    check("mul_5_3", io_out, 8'h0F);
    check_int("done_count_ops", done_cnt, 5);

    // Clear during MUL1 aborts with no done.
    drive(1, 1, 3'd7, 0);
    drive(1, 0, 3'd7, 0);
    drive(0, 0, 3'd0, 0);
    drive(0, 0, 3'd0, 1);
    drive(0, 0, 3'd0, 0);
    check("clear_mid_mul", io_out, 8'h00);
    idle(4);
    check("clear_mid_mul_settled", io_out, 8'h00);
    check_int("done_count_clear", done_cnt, 5);

    // Clear beats valid in IDLE.
    drive(1, 0, 3'd3, 1);
    drive(0, 0, 3'd0, 0);
    check("clear_beats_valid", io_out, 8'h00);

    // Held valid: 3*2, then valid stays high through DONE.
    drive(1, 1, 3'd3, 0);
    drive(1, 0, 3'd2, 0);
    repeat (4) drive(1, 0, 3'd5, 0);
    drive(0, 0, 3'd0, 0);
    check("held_valid_mul", io_out, 8'h06);
    idle(2);
    check("held_valid_no_capture", io_out, 8'h06);
    check_int("done_count_held", done_cnt, 6);

    // Reset mid-operation: no done for the aborted multiply.
    drive(1, 1, 3'd7, 0);
    drive(1, 0, 3'd7, 0);
    drive(0, 0, 3'd0, 0);
    #2 rst_n = 1'b0;
    #1 check("reset_mid_op", io_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    idle(6);
    check("reset_mid_op_after", io_out, 8'h00);
    check_int("done_count_reset", done_cnt, 6);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adder3_sequencer.md
# adder3_sequencer

Sequencing controller for the 3-bit ripple-carry adder datapath on a TinyTapeout user slot. It collects two 3-bit operands over the shared input pins and drives the adder once for an add or three times for a shift-add multiply. It registers a 6-bit result and flags completion. It sits between the slot's `io_in`/`io_out` pins and the adder gate network, so one adder serves both operations.

## Interface
Parameters:
- None. Operand width is fixed at 3 bits and result width at 6 bits by the slot's pin budget.

Ports (module ports are `io_in[7:0]` and `io_out[7:0]`; the bit fields are listed below):
- `io_in[0]` (clk), input, 1: sole clock, rising edge.
- `io_in[1]` (rst_n), input, 1: asynchronous, active-low reset.
- `io_in[2]` (valid), input, 1: operand strobe, sampled on each rising edge.
- `io_in[3]` (mode), input, 1: operation select, 0 = add, 1 = multiply. Sampled with operand A.
- `io_in[6:4]` (data), input, 3: operand value.
- `io_in[7]` (clear), input, 1: synchronous abort and result clear.
- `io_out[5:0]` (result), output, 6: registered result.
- `io_out[6]` (busy), output, 1: high whenever the state is not IDLE.
- `io_out[7]` (done), output, 1: one-cycle completion pulse.

## Operation
- States: IDLE, WAIT_B, ADD, MUL0, MUL1, MUL2, DONE.
- IDLE:
  - On `valid`=1: A <= `data`, mode_r <= `mode`, go to WAIT_B.
- WAIT_B:
  - On `valid`=1: B <= `data`, P <= 0.
  - Next state is ADD when mode_r=0, MUL0 when mode_r=1.
- ADD:
  - X = A + B, a 4-bit sum zero-extended to 6 bits.
  - Final write, then go to DONE.
- MULi (i = 0, 1, 2):
  - P[i+3:i] <= P[i+2:i] + (B[i] ? A : 0). This uses the 3-bit adder with carry-out into P[i+3].
  - Bits of P below i are unchanged.
  - No overflow is possible in any step.
  - MUL2 sets X = final P, does the final write, and goes to DONE.
- Final write:
  - result <= X (see Configuration for the alternative).
  - `result` holds its value at all other times.
- DONE:
  - `done`=1 for exactly one cycle, then go to IDLE.
  - `valid` is ignored while in DONE.
- `valid` is level-sampled. If it is held high, A and B are captured on consecutive edges.
- `valid` is ignored in ADD, MUL0, MUL1, MUL2 and DONE.
- `clear`=1 at a rising edge:
  - From any state, go to IDLE.
  - result <= 0, `done` <= 0. A, B and P are don't-care.
  - Takes priority over `valid` and over a same-cycle final write.
- Reset (`rst_n`=0): immediately, with no clock required, state = IDLE and A, B, P, mode_r, result = 0.

## Timing
- Reset values: `io_out` = 8'h00 (result 0, busy 0, done 0).
- `busy` and `done` are decoded from registered state, so they are glitch-free at the pins.
- Latency is counted from the edge that captures B (edge n):
  - Add: result updates at edge n+1. `done` is high from n+1 to n+2.
  - Multiply: result updates at edge n+3. `done` is high from n+3 to n+4.
- `busy` rises at the edge that captures A and falls at the edge that leaves DONE.
- Minimum period from A capture to the next A capture: add 4 cycles, multiply 6 cycles.
- Reset deasserted mid-operation: the block starts in IDLE. No `done` is issued for the aborted operation.

## Configuration
- `ADDER3_SEQ_ACCUM_EN` defined:
  - The final write is result <= (result + X) mod 64, so add and multiply results accumulate.
  - `clear` is the only way to zero the accumulator other than reset.
  - The accumulator adder is a 6-bit add performed in the same cycle as the final write.
- `ADDER3_SEQ_ACCUM_EN` undefined:
  - The final write is result <= X, and the previous result is discarded.
  - No 6-bit accumulate adder is instantiated.

## Test plan
- Reset: drive rst_n=0 with the clock stopped -> `io_out`=8'h00. Release reset, clock 3 edges with valid=0 -> `io_out` stays 8'h00.
- Add: A=5, mode=0, then B=6 -> `result`=11 at edge n+1, `done` pulses 1 cycle, `busy` falls 1 cycle after that. Repeat with 7+7 -> `result`=14.
- Multiply: 7*7 -> `result`=49 at edge n+3. 5*3 -> 15. 0*6 -> 0. In each case `done` pulses exactly once and the result does not change during MUL0 or MUL1.
- Clear mid-multiply: assert clear during MUL1 -> next cycle IDLE, `result`=0, `busy`=0, and no `done` pulse. Assert clear in the same cycle as valid in IDLE -> no capture.
- Held valid: keep valid=1 with data=3 then data=2 on consecutive edges, mode=1 -> product 6. Valid stays high through DONE -> no new capture until IDLE.
- With `ADDER3_SEQ_ACCUM_EN`: 3+4 then 3+4 -> 7 then 14. 7*7 then 7*7 from clear -> 49 then 34 (98 mod 64). Clear -> 0.
